// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and
// pipe_hazard_ctrl.
//   master : the pipeline side. It drives hazard sources and receives the
//            stall/bubble controls.
//   slave  : the controller side.
// Handshake semantics: there is no valid/ready pair here. Every input is a
// level that is sampled each rising clock edge. The controls are
// combinational and apply to the same cycle. Data memory completes a
// request in the cycle where dmem_req and dmem_ready are both high.
// With PIPE_HAZARD_PERF_EN defined, three 32-bit performance counters are
// added to the bundle.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_Rs;
    logic [4:0] id_Rt;
    logic       id_uses_rt;
    logic       ex_MemtoReg;
    logic       ex_RegWr;
    logic [4:0] ex_Rw;
    logic       jump_ex;
    logic       branch_mem;
    logic       dmem_req;
    logic       dmem_ready;
    logic       halt_req;
    logic       resume;
    logic       pc_stall;
    logic       if_stall;
    logic       if_bubble;
    logic       id_stall;
    logic       id_bubble;
    logic       ex_stall;
    logic       ex_bubble;
    logic       mem_stall;
    logic       mem_bubble;
    logic       halted;
    logic       mem_timeout;
    logic [1:0] state_dbg;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_wait_cyc;
`endif

    modport master (
        output id_Rs, id_Rt, id_uses_rt, ex_MemtoReg, ex_RegWr, ex_Rw,
               jump_ex, branch_mem, dmem_req, dmem_ready, halt_req, resume,
        input  pc_stall, if_stall, if_bubble, id_stall, id_bubble,
               ex_stall, ex_bubble, mem_stall, mem_bubble, halted,
               mem_timeout, state_dbg
`ifdef PIPE_HAZARD_PERF_EN
        , input perf_stall_cyc, perf_flush_cnt, perf_wait_cyc
`endif
    );

    modport slave (
        input  id_Rs, id_Rt, id_uses_rt, ex_MemtoReg, ex_RegWr, ex_Rw,
               jump_ex, branch_mem, dmem_req, dmem_ready, halt_req, resume,
        output pc_stall, if_stall, if_bubble, id_stall, id_bubble,
               ex_stall, ex_bubble, mem_stall, mem_bubble, halted,
               mem_timeout, state_dbg
`ifdef PIPE_HAZARD_PERF_EN
        , output perf_stall_cyc, perf_flush_cnt, perf_wait_cyc
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: the central stall/bubble scheduler for the 5-stage
// pipeline. It handles:
//   - post-reset warm-up (INIT),
//   - data-memory freezes and the sticky wait timeout,
//   - branch and jump flushes,
//   - load-use stalls,
//   - the halt / drain / resume sequence.
// Optional macro PIPE_HAZARD_PERF_EN adds the perf_stall_cyc,
// perf_flush_cnt and perf_wait_cyc counters.
module pipe_hazard_ctrl #(
    parameter int INIT_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int WAIT_MAX     = 255,
    parameter int CNT_W        = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN, ST_HALTED} state_e;

    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LIM   = CNT_W'(WAIT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic             freeze, load_use;
    logic             lu_evt, flush_evt, frz_evt;
    logic             pc_stall, if_stall, if_bubble, id_stall, id_bubble;
    logic             ex_stall, ex_bubble, mem_stall, mem_bubble, halted;

    // Hazard detection. The freeze term only matters in RUN and DRAIN.
    always_comb begin
        freeze   = (state_q == ST_RUN || state_q == ST_DRAIN) &&
                   hz.dmem_req && !hz.dmem_ready;
        load_use = hz.ex_MemtoReg && hz.ex_RegWr && (hz.ex_Rw != 5'd0) &&
                   ((hz.ex_Rw == hz.id_Rs) ||
                    (hz.id_uses_rt && (hz.ex_Rw == hz.id_Rt)));
    end

    // Next state, counters and the combinational stall/bubble controls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = '0;
        timeout_d  = timeout_q;
        pc_stall   = 1'b0;
        if_stall   = 1'b0;
        if_bubble  = 1'b0;
        id_stall   = 1'b0;
        id_bubble  = 1'b0;
        ex_stall   = 1'b0;
        ex_bubble  = 1'b0;
        mem_stall  = 1'b0;
        mem_bubble = 1'b0;
        halted     = 1'b0;
        lu_evt     = 1'b0;
        flush_evt  = 1'b0;
        frz_evt    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                pc_stall   = 1'b1;
                if_bubble  = 1'b1;
                id_bubble  = 1'b1;
                ex_bubble  = 1'b1;
                mem_bubble = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (freeze) begin
                    // The whole pipeline holds and MEM/WB takes a bubble.
                    // The wait counter saturates at the limit, so a long
                    // freeze cannot wrap it back below the timeout.
                    frz_evt    = 1'b1;
                    pc_stall   = 1'b1;
                    if_stall   = 1'b1;
                    id_stall   = 1'b1;
                    ex_stall   = 1'b1;
                    mem_bubble = 1'b1;
                    wait_d     = (wait_q == WAIT_LIM) ? wait_q : wait_q + 1'b1;
                    if (wait_d == WAIT_LIM) timeout_d = 1'b1;
                end else if (hz.branch_mem) begin
                    // A taken branch also cancels a halt that was on the
                    // wrong path.
                    flush_evt = 1'b1;
                    if_bubble = 1'b1;
                    id_bubble = 1'b1;
                    ex_bubble = 1'b1;
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                end else if (state_q == ST_DRAIN) begin
                    // The halt sits in IF/ID while the older instructions
                    // retire.
                    pc_stall  = 1'b1;
                    if_stall  = 1'b1;
                    id_bubble = 1'b1;
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = ST_HALTED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (hz.jump_ex) begin
                    flush_evt = 1'b1;
                    if_bubble = 1'b1;
                    id_bubble = 1'b1;
                end else if (load_use) begin
                    lu_evt    = 1'b1;
                    pc_stall  = 1'b1;
                    if_stall  = 1'b1;
                    id_bubble = 1'b1;
                end else if (hz.halt_req) begin
                    // The drain controls already apply in this cycle.
                    pc_stall  = 1'b1;
                    if_stall  = 1'b1;
                    id_bubble = 1'b1;
                    state_d   = ST_DRAIN;
                    cnt_d     = '0;
                end
            end
            ST_HALTED: begin
                if (hz.resume) begin
                    // Bubbling IF/ID discards the halt instruction.
                    if_bubble = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    pc_stall  = 1'b1;
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_stall  = 1'b1;
                    mem_stall = 1'b1;
                    halted    = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State, counter and sticky-timeout registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.if_stall    = if_stall;
    assign hz.if_bubble   = if_bubble;
    assign hz.id_stall    = id_stall;
    assign hz.id_bubble   = id_bubble;
    assign hz.ex_stall    = ex_stall;
    assign hz.ex_bubble   = ex_bubble;
    assign hz.mem_stall   = mem_stall;
    assign hz.mem_bubble  = mem_bubble;
    assign hz.halted      = halted;
    assign hz.mem_timeout = timeout_d;
    assign hz.state_dbg   = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Event counters, free-running and wrapping at 2^32.
    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, lu_evt};
        perf_flush_d = perf_flush_q + {31'd0, flush_evt};
        perf_wait_d  = perf_wait_q + {31'd0, frz_evt};
    end

    // Performance counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_wait_q  <= perf_wait_d;
        end
    end

    assign hz.perf_stall_cyc = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
    assign hz.perf_wait_cyc  = perf_wait_q;
`else
    logic unused_evt;
    assign unused_evt = lu_evt ^ flush_evt ^ frz_evt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Inputs change just after the
// falling edge. Outputs are sampled 1 ns later, well away from the rising
// edge. Control vector bit order:
// {pc_stall, if_stall, if_bubble, id_stall, id_bubble, ex_stall, ex_bubble,
//  mem_stall, mem_bubble}.
module tb_pipe_hazard_ctrl;
    localparam logic [8:0] O_IDLE   = 9'b0_0000_0000;
    localparam logic [8:0] O_INIT   = 9'b1_0101_0101;
    localparam logic [8:0] O_LU     = 9'b1_1001_0000;
    localparam logic [8:0] O_BR     = 9'b0_0101_0100;
    localparam logic [8:0] O_JMP    = 9'b0_0101_0000;
    localparam logic [8:0] O_FRZ    = 9'b1_1010_1001;
    localparam logic [8:0] O_HALT   = 9'b1_1010_1010;
    localparam logic [8:0] O_RESUME = 9'b0_0100_0000;
    localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz)
    );

    // Clock and watchdog.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs();
        return {hz.pc_stall, hz.if_stall, hz.if_bubble, hz.id_stall,
                hz.id_bubble, hz.ex_stall, hz.ex_bubble, hz.mem_stall,
                hz.mem_bubble};
    endfunction

    // Driver tasks.
    task automatic idle_inputs();
        hz.id_Rs       = 5'd0;
        hz.id_Rt       = 5'd0;
        hz.id_uses_rt  = 1'b0;
        hz.ex_MemtoReg = 1'b0;
        hz.ex_RegWr    = 1'b0;
        hz.ex_Rw       = 5'd0;
        hz.jump_ex     = 1'b0;
        hz.branch_mem  = 1'b0;
        hz.dmem_req    = 1'b0;
        hz.dmem_ready  = 1'b0;
        hz.halt_req    = 1'b0;
        hz.resume      = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge Clk);
        idle_inputs();
    endtask

    task automatic set_load(input logic [4:0] rw, input logic [4:0] rs,
                            input logic [4:0] rt, input logic uses_rt,
                            input logic regwr);
        hz.ex_MemtoReg = 1'b1;
        hz.ex_RegWr    = regwr;
        hz.ex_Rw       = rw;
        hz.id_Rs       = rs;
        hz.id_Rt       = rt;
        hz.id_uses_rt  = uses_rt;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if (obs() !== O_INIT) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b", obs(), O_INIT);
        end
        checks++;
        if (hz.halted !== 1'b0 || hz.mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: halted %b timeout %b want 0 0",
                     hz.halted, hz.mem_timeout);
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) next_cycle();
            #1;
            checks++;
            if (obs() !== O_INIT) begin
                errors++;
                $display("FAIL init_cycle%0d: got %b want %b", i, obs(), O_INIT);
            end
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== O_IDLE || hz.state_dbg !== S_RUN) begin
            errors++;
            $display("FAIL init_to_run: got %b st %0d want %b st %0d",
                     obs(), hz.state_dbg, O_IDLE, S_RUN);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs() !== O_LU) begin
            errors++;
            $display("FAIL lu_rs: got %b want %b", obs(), O_LU);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== O_IDLE) begin
            errors++;
            $display("FAIL lu_one_cycle: got %b want %b", obs(), O_IDLE);
        end
        next_cycle();
        set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        checks++;
        if (obs() !== O_IDLE) begin
            errors++;
            $display("FAIL lu_r0: got %b want %b", obs(), O_IDLE);
        end
        next_cycle();
        set_load(5'd9, 5'd1, 5'd9, 1'b1, 1'b1);
        #1;
        checks++;
        if (obs() !== O_LU) begin
            errors++;
            $display("FAIL lu_rt: got %b want %b", obs(), O_LU);
        end
        next_cycle();
        set_load(5'd9, 5'd1, 5'd9, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs() !== O_IDLE) begin
            errors++;
            $display("FAIL lu_rt_unused: got %b want %b", obs(), O_IDLE);
        end
        next_cycle();
        set_load(5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs() !== O_IDLE) begin
            errors++;
            $display("FAIL lu_no_regwr: got %b want %b", obs(), O_IDLE);
        end
    endtask

    task automatic test_flush_priority();
        next_cycle();
        set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        hz.branch_mem = 1'b1;
        hz.jump_ex    = 1'b1;
        #1;
        checks++;
        if (obs() !== O_BR) begin
            errors++;
            $display("FAIL branch_prio: got %b want %b", obs(), O_BR);
        end
        next_cycle();
        set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        hz.jump_ex = 1'b1;
        #1;
        checks++;
        if (obs() !== O_JMP) begin
            errors++;
            $display("FAIL jump_prio: got %b want %b", obs(), O_JMP);
        end
        next_cycle();
        hz.branch_mem = 1'b1;
        hz.halt_req   = 1'b1;
        #1;
        checks++;
        if (obs() !== O_BR) begin
            errors++;
            $display("FAIL branch_halt: got %b want %b", obs(), O_BR);
        end
        next_cycle();
        set_load(5'd3, 5'd3, 5'd0, 1'b0, 1'b1);
        hz.halt_req = 1'b1;
        #1;
        checks++;
        if (obs() !== O_LU) begin
            errors++;
            $display("FAIL lu_halt: got %b want %b", obs(), O_LU);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== O_IDLE || hz.state_dbg !== S_RUN) begin
            errors++;
            $display("FAIL halt_ignored: got %b st %0d want %b st %0d",
                     obs(), hz.state_dbg, O_IDLE, S_RUN);
        end
    endtask

    task automatic test_freeze();
        logic exp_to;
        for (int i = 1; i <= 300; i++) begin
            next_cycle();
            hz.dmem_req   = 1'b1;
            hz.branch_mem = (i == 10);
            hz.halt_req   = (i == 20);
            #1;
            exp_to = (i >= 255);
            checks++;
            if (obs() !== O_FRZ) begin
                errors++;
                $display("FAIL freeze_ctrl c%0d: got %b want %b", i, obs(), O_FRZ);
            end
            checks++;
            if (hz.mem_timeout !== exp_to) begin
                errors++;
                $display("FAIL freeze_timeout c%0d: got %b want %b",
                         i, hz.mem_timeout, exp_to);
            end
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            hz.dmem_req   = (i == 0);
            hz.dmem_ready = (i == 0);
            #1;
            checks++;
            if (obs() !== O_IDLE || hz.mem_timeout !== 1'b1 || hz.state_dbg !== S_RUN) begin
                errors++;
                $display("FAIL after_freeze%0d: got %b to %b st %0d want %b to 1 st %0d",
                         i, obs(), hz.mem_timeout, hz.state_dbg, O_IDLE, S_RUN);
            end
        end
    endtask

    task automatic test_halt_resume();
        // Expected per cycle: halt, drain, freeze, drain, drain, halted x2.
        logic [8:0] exp_o[7];
        logic       exp_h[7];
        exp_o = '{O_LU, O_LU, O_FRZ, O_LU, O_LU, O_HALT, O_HALT};
        exp_h = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            hz.halt_req = (i == 0);
            hz.dmem_req = (i == 2);
            #1;
            checks++;
            if (obs() !== exp_o[i] || hz.halted !== exp_h[i]) begin
                errors++;
                $display("FAIL halt_seq%0d: got %b h %b want %b h %b",
                         i, obs(), hz.halted, exp_o[i], exp_h[i]);
            end
        end
        next_cycle();
        hz.resume = 1'b1;
        #1;
        checks++;
        if (obs() !== O_RESUME || hz.halted !== 1'b0) begin
            errors++;
            $display("FAIL resume: got %b h %b want %b h 0",
                     obs(), hz.halted, O_RESUME);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== O_IDLE || hz.state_dbg !== S_RUN) begin
            errors++;
            $display("FAIL after_resume: got %b st %0d want %b st %0d",
                     obs(), hz.state_dbg, O_IDLE, S_RUN);
        end
        next_cycle();
        hz.resume = 1'b1;
        #1;
        checks++;
        if (obs() !== O_IDLE || hz.state_dbg !== S_RUN) begin
            errors++;
            $display("FAIL resume_in_run: got %b st %0d want %b st %0d",
                     obs(), hz.state_dbg, O_IDLE, S_RUN);
        end
    endtask

    task automatic test_drain_branch_reset();
        next_cycle();
        hz.halt_req = 1'b1;
        #1;
        next_cycle();
        #1;
        checks++;
        if (obs() !== O_LU || hz.state_dbg !== S_DRAIN) begin
            errors++;
            $display("FAIL drain1: got %b st %0d want %b st %0d",
                     obs(), hz.state_dbg, O_LU, S_DRAIN);
        end
        next_cycle();
        hz.branch_mem = 1'b1;
        #1;
        checks++;
        if (obs() !== O_BR) begin
            errors++;
            $display("FAIL drain_branch: got %b want %b", obs(), O_BR);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            checks++;
            if (obs() !== O_IDLE || hz.halted !== 1'b0 || hz.state_dbg !== S_RUN) begin
                errors++;
                $display("FAIL post_branch%0d: got %b h %b st %0d want %b h 0 st %0d",
                         i, obs(), hz.halted, hz.state_dbg, O_IDLE, S_RUN);
            end
        end
        next_cycle();
        hz.halt_req = 1'b1;
        #1;
        next_cycle();
        #1;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (obs() !== O_INIT || hz.halted !== 1'b0 || hz.mem_timeout !== 1'b0 ||
            hz.state_dbg !== S_INIT) begin
            errors++;
            $display("FAIL reset_mid_drain: got %b h %b to %b st %0d want %b 0 0 %0d",
                     obs(), hz.halted, hz.mem_timeout, hz.state_dbg, O_INIT, S_INIT);
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        #1;
        checks++;
        if (obs() !== O_IDLE || hz.state_dbg !== S_RUN) begin
            errors++;
            $display("FAIL rerun_after_reset: got %b st %0d want %b st %0d",
                     obs(), hz.state_dbg, O_IDLE, S_RUN);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_flush_priority();
        test_freeze();
        test_halt_resume();
        test_drain_branch_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/bubble scheduler for the 5-stage pipeline. It drives the stall and bubble inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branch/jump flushes and data-memory wait states. It also sequences post-reset warm-up and a halt/drain/resume protocol.

Parameters:
INIT_CYCLES, 4, cycles of full-pipeline bubbling after reset release (1..15)
DRAIN_CYCLES, 3, cycles needed to empty ID/EX..MEM/WB behind a halt (1..15)
WAIT_MAX, 255, data-memory wait cycles before mem_timeout asserts (1..2^CNT_W-1)
CNT_W, 8, width of the internal wait/drain counter

Ports:
Clk in 1 clock, all state on rising edge
Reset in 1 asynchronous, active-high; clears all state immediately
id_Rs in 5 Rs field of instruction in ID
id_Rt in 5 Rt field of instruction in ID
id_uses_rt in 1 instruction in ID reads Rt
ex_MemtoReg in 1 instruction in EX is a load
ex_RegWr in 1 instruction in EX writes a register
ex_Rw in 5 destination register of instruction in EX
jump_ex in 1 jump resolved in EX
branch_mem in 1 branch taken, resolved in MEM
dmem_req in 1 MEM stage accesses data memory this cycle
dmem_ready in 1 data memory completes this cycle
halt_req in 1 halt instruction decoded in ID
resume in 1 single-cycle pulse, leave HALTED
pc_stall out 1 hold PC
if_stall, if_bubble out 1 each, IF/ID register control
id_stall, id_bubble out 1 each, ID/EX register control
ex_stall, ex_bubble out 1 each, EX/MEM register control
mem_stall, mem_bubble out 1 each, MEM/WB register control
halted out 1 pipeline drained and held
mem_timeout out 1 sticky, wait exceeded WAIT_MAX

Behaviour:
- States: INIT, RUN, DRAIN, HALTED. Reset (async) -> INIT, counter=0, mem_timeout=0.
- Outputs are combinational from state and inputs. Never assert stall and bubble for the same register in one cycle.
- During Reset and in INIT: pc_stall=1, all four *_bubble=1, all other stalls=0. Counter increments each cycle. At counter==INIT_CYCLES-1 -> RUN, counter cleared.
- freeze = dmem_req & !dmem_ready, evaluated in RUN and DRAIN; freeze has top priority.
  - During freeze: pc_stall, if_stall, id_stall, ex_stall = 1, mem_bubble=1. State and counter hold, except the wait counter.
  - Wait counter increments per frozen cycle and clears when freeze drops. Reaching WAIT_MAX sets mem_timeout, which stays set until Reset. Freezing continues after timeout.
- RUN, not frozen, priority order:
  1. branch_mem: if_bubble, id_bubble, ex_bubble = 1; PC loads target (pc_stall=0). halt_req ignored.
  2. jump_ex: if_bubble, id_bubble = 1.
  3. Load-use: ex_MemtoReg & ex_RegWr & ex_Rw!=0 & (ex_Rw==id_Rs | id_uses_rt & ex_Rw==id_Rt). Asserts pc_stall, if_stall, id_bubble for exactly that cycle. halt_req is ignored this cycle.
  4. halt_req: -> DRAIN, counter=0. Drain outputs apply from this same cycle.
  5. Otherwise all outputs 0.
- DRAIN, not frozen: pc_stall, if_stall, id_bubble = 1 (halt stays in IF/ID). Counter increments; at DRAIN_CYCLES-1 -> HALTED.
  - branch_mem in DRAIN: halt was on the wrong path. Apply the branch flush, go to RUN, clear counter.
- HALTED: pc_stall, if_stall, id_stall, ex_stall, mem_stall = 1; halted=1.
  - On resume: if_bubble=1 (discards halt), pc_stall=0, all other stalls=0, -> RUN.
  - resume outside HALTED is ignored.
- Reset mid-freeze or mid-drain: return to INIT immediately. halted=0 and mem_timeout=0 during Reset.

Optional Feature:
PIPE_HAZARD_PERF_EN: when defined, add three outputs, each 32-bit: perf_stall_cyc, perf_flush_cnt and perf_wait_cyc.
- perf_stall_cyc counts RUN load-use cycles.
- perf_flush_cnt counts branch_mem/jump_ex flush events.
- perf_wait_cyc counts frozen cycles.
- All three clear on Reset and wrap at 2^32.
When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset pulse then idle inputs -> pc_stall=1 and all bubbles=1 for exactly 4 cycles after release, then all outputs 0.
2. RUN with ex_MemtoReg=1, ex_RegWr=1, ex_Rw=5, id_Rs=5 for one cycle -> pc_stall=if_stall=id_bubble=1 that cycle only. Same with ex_Rw=0 -> no stall.
3. branch_mem=1 and jump_ex=1 together with a load-use hazard -> if/id/ex_bubble=1, pc_stall=0, no stall outputs.
4. dmem_req=1, dmem_ready=0 for 300 cycles with WAIT_MAX=255 -> pipeline frozen throughout with mem_bubble=1. mem_timeout rises on the 255th frozen cycle and stays 1 after dmem_ready=1.
5. halt_req in RUN -> DRAIN for 3 cycles, then halted=1 with all stalls held. resume pulse -> if_bubble=1 for one cycle, halted=0, back to RUN.
6. halt_req, then branch_mem=1 on the 2nd DRAIN cycle -> flush bubbles applied, state RUN, halted never asserts. Reset asserted mid-DRAIN -> immediate INIT outputs.
